int_to_float: RTL

- Sequential converter from a 32-bit two's-complement integer to an IEEE-754 single-precision float.
- Sits directly upstream of the floating-point adder and drives one of the adder's operand ports.
- Uses the same stb/ack handshake as the rest of the fpu blocks.
- Normalisation is bit-serial, one shift per cycle, so latency depends on the input value.

---
 rtl/int_to_float_if.sv | 19 +
 rtl/int_to_float.sv | 139 +++++++++++++
 2 files changed

// File: rtl/int_to_float_if.sv
// Handshake bundle between an integer producer, int_to_float and the float consumer.
interface int_to_float_if;
   logic [31:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   modport slave (
      input  input_a, input_a_stb, output_z_ack,
      output input_a_ack, output_z, output_z_stb
   );

   modport master (
      output input_a, input_a_stb, output_z_ack,
      input  input_a_ack, output_z, output_z_stb
   );
endinterface

// File: rtl/int_to_float.sv
// Bit-serial 32-bit integer to IEEE single converter, stb/ack on both sides.
// Define INT_TO_FLOAT_UNSIGNED_EN to treat input_a as unsigned.
module int_to_float (
   input  logic           clk,
   input  logic           rst,
   int_to_float_if.slave  bus
);
   typedef enum logic [2:0] {
      GET_A, CONVERT_0, CONVERT_1, CONVERT_2, ROUND, PACK, PUT_Z
   } state_t;

   state_t             state, state_nxt;
   logic [31:0]        a, a_nxt;
   logic [31:0]        value, value_nxt;
   logic [23:0]        z_m, z_m_nxt;
   logic signed [9:0]  z_e, z_e_nxt;
   logic               z_s, z_s_nxt;
   logic               guard, guard_nxt;
   logic               round_bit, round_bit_nxt;
   logic               sticky, sticky_nxt;
   logic [31:0]        z, z_nxt;
   logic               ack, ack_nxt;
   logic               stb, stb_nxt;
   logic [31:0]        out, out_nxt;

   assign bus.input_a_ack  = ack;
   assign bus.output_z_stb = stb;
   assign bus.output_z     = out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= GET_A;
         a         <= '0;
         value     <= '0;
         z_m       <= '0;
         z_e       <= '0;
         z_s       <= 1'b0;
         guard     <= 1'b0;
         round_bit <= 1'b0;
         sticky    <= 1'b0;
         z         <= '0;
         ack       <= 1'b0;
         stb       <= 1'b0;
         out       <= '0;
      end else begin
         state     <= state_nxt;
         a         <= a_nxt;
         value     <= value_nxt;
         z_m       <= z_m_nxt;
         z_e       <= z_e_nxt;
         z_s       <= z_s_nxt;
         guard     <= guard_nxt;
         round_bit <= round_bit_nxt;
         sticky    <= sticky_nxt;
         z         <= z_nxt;
         ack       <= ack_nxt;
         stb       <= stb_nxt;
         out       <= out_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      a_nxt         = a;
      value_nxt     = value;
      z_m_nxt       = z_m;
      z_e_nxt       = z_e;
      z_s_nxt       = z_s;
      guard_nxt     = guard;
      round_bit_nxt = round_bit;
      sticky_nxt    = sticky;
      z_nxt         = z;
      ack_nxt       = ack;
      stb_nxt       = stb;
      out_nxt       = out;
      case (state)
         GET_A: begin
            ack_nxt = 1'b1;
            if (ack && bus.input_a_stb) begin
               a_nxt     = bus.input_a;
               ack_nxt   = 1'b0;
               state_nxt = CONVERT_0;
            end
         end
         CONVERT_0: begin
            if (a == 32'h0) begin
               z_nxt     = 32'h0;
               state_nxt = PUT_Z;
            end else begin
`ifdef INT_TO_FLOAT_UNSIGNED_EN
               z_s_nxt   = 1'b0;
               value_nxt = a;
`else
               // 0x80000000 negates to itself, which reads as magnitude 2^31
               z_s_nxt   = a[31];
               value_nxt = a[31] ? (~a + 32'd1) : a;
`endif
               z_e_nxt   = 10'sd31;
               state_nxt = CONVERT_1;
            end
         end
         CONVERT_1: begin
            if (!value[31]) begin
               value_nxt = value << 1;
               z_e_nxt   = z_e - 10'sd1;
            end else begin
               state_nxt = CONVERT_2;
            end
         end
         CONVERT_2: begin
            z_m_nxt       = value[31:8];
            guard_nxt     = value[7];
            round_bit_nxt = value[6];
            sticky_nxt    = |value[5:0];
            state_nxt     = ROUND;
         end
         ROUND: begin
            if (guard && (round_bit || sticky || z_m[0])) begin
               z_m_nxt = z_m + 24'd1;
               if (z_m == 24'hFFFFFF) z_e_nxt = z_e + 10'sd1;
            end
            state_nxt = PACK;
         end
         PACK: begin
            z_nxt     = {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
            state_nxt = PUT_Z;
         end
         PUT_Z: begin
            stb_nxt = 1'b1;
            out_nxt = z;
            if (stb && bus.output_z_ack) begin
               stb_nxt   = 1'b0;
               state_nxt = GET_A;
            end
         end
         default: state_nxt = GET_A;
      endcase
   end
endmodule
